cclu_arbiter: RTL and testbench

- Shares one call-counter lookup unit (CCLU) between NUM_REQ requesters.
- Arbitrates round-robin, sequences each command through the CCLU's fixed response timing, and returns valid/error/target to the winning requester.
- Also sequences CCLU flush: clear pin together with cmd 11.
- Sits between the fetch/branch requesters and the CCLU instance.

---
 rtl/cclu_arbiter_if.sv | 55 +++++
 rtl/cclu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cclu_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cclu_arbiter_if.sv
// Requester and CCLU bus bundle for cclu_arbiter.
// Statistics signals exist only when CCLU_ARB_STATS_EN is defined.
interface cclu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [2*NUM_REQ-1:0]  req_cmd;
    logic [AW*NUM_REQ-1:0] req_addr;
    logic [AW*NUM_REQ-1:0] req_target;
    logic [AW*NUM_REQ-1:0] req_counter;
    logic                  flush_req;
    logic                  flush_done;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ok;
    logic                  rsp_error;
    logic [AW-1:0]         rsp_target;
    logic                  busy;
    logic [1:0]            cclu_cmd;
    logic [AW-1:0]         cclu_addr;
    logic [AW-1:0]         cclu_target;
    logic [AW-1:0]         cclu_counter;
    logic                  cclu_clear;
    logic                  cclu_valid;
    logic                  cclu_error;
    logic                  cclu_full;
    logic [AW-1:0]         cclu_target_out;
`ifdef CCLU_ARB_STATS_EN
    logic [15:0]           err_count;
    logic [16*NUM_REQ-1:0] grant_count;
`endif

    modport slave (
        input  req_valid, req_cmd, req_addr, req_target, req_counter, flush_req,
        input  cclu_valid, cclu_error, cclu_full, cclu_target_out,
        output flush_done, rsp_valid, rsp_id, rsp_ok, rsp_error, rsp_target, busy,
        output cclu_cmd, cclu_addr, cclu_target, cclu_counter, cclu_clear
`ifdef CCLU_ARB_STATS_EN
        , output err_count, grant_count
`endif
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_target, req_counter, flush_req,
        output cclu_valid, cclu_error, cclu_full, cclu_target_out,
        input  flush_done, rsp_valid, rsp_id, rsp_ok, rsp_error, rsp_target, busy,
        input  cclu_cmd, cclu_addr, cclu_target, cclu_counter, cclu_clear
`ifdef CCLU_ARB_STATS_EN
        , input err_count, grant_count
`endif
    );
endinterface

// File: rtl/cclu_arbiter.sv
// Round-robin arbiter sharing one CCLU between NUM_REQ requesters, with flush sequencing.
// Optional statistics counters are enabled by defining CCLU_ARB_STATS_EN.
module cclu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32
) (
    input  logic           clk,
    input  logic           reset,
    cclu_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, CAP, RESP, FLUSH, FWAIT
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] pick;
    logic           pick_found;
    int unsigned    rr_idx;

    logic [1:0]     cmd_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  target_q;
    logic [AW-1:0]  counter_q;
    logic           ok_q;
    logic           err_q;
    logic [AW-1:0]  rsp_target_q;

    logic [1:0]     lane_cmd     [NUM_REQ];
    logic [AW-1:0]  lane_addr    [NUM_REQ];
    logic [AW-1:0]  lane_target  [NUM_REQ];
    logic [AW-1:0]  lane_counter [NUM_REQ];
    logic [1:0]     pick_cmd;
    logic           pick_fwd;

    // Full is informational only; pushes are forwarded regardless.
    logic unused_full;
    assign unused_full = bus.cclu_full;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_cmd[g]     = bus.req_cmd[g*2 +: 2];
        assign lane_addr[g]    = bus.req_addr[g*AW +: AW];
        assign lane_target[g]  = bus.req_target[g*AW +: AW];
        assign lane_counter[g] = bus.req_counter[g*AW +: AW];
    end

    // Search upward from rr_ptr+1 with wrap; the last granted requester goes last.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        rr_idx     = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = 32'(rr_ptr) + i;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            if (!pick_found && bus.req_valid[IDW'(rr_idx)]) begin
                pick       = IDW'(rr_idx);
                pick_found = 1'b1;
            end
        end
    end

    assign pick_cmd = lane_cmd[pick];
    assign pick_fwd = (pick_cmd == 2'b01) || (pick_cmd == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.busy         = (state != IDLE);
        bus.cclu_cmd     = 2'b00;
        bus.cclu_clear   = 1'b0;
        bus.cclu_addr    = '0;
        bus.cclu_target  = '0;
        bus.cclu_counter = '0;
        bus.flush_done   = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_id       = '0;
        bus.rsp_ok       = 1'b0;
        bus.rsp_error    = 1'b0;
        bus.rsp_target   = '0;
        case (state)
            IDLE: begin
                if (bus.flush_req)   state_nxt = FLUSH;
                else if (pick_found) state_nxt = pick_fwd ? ISSUE : RESP;
            end
            ISSUE: begin
                bus.cclu_cmd     = cmd_q;
                bus.cclu_addr    = addr_q;
                bus.cclu_target  = target_q;
                bus.cclu_counter = counter_q;
                state_nxt        = WAIT;
            end
            WAIT: begin
                bus.cclu_target = target_q;
                state_nxt       = CAP;
            end
            CAP: begin
                bus.cclu_target = target_q;
                state_nxt       = RESP;
            end
            RESP: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_id     = grant;
                bus.rsp_ok     = ok_q;
                bus.rsp_error  = err_q;
                bus.rsp_target = rsp_target_q;
                state_nxt      = IDLE;
            end
            FLUSH: begin
                bus.cclu_clear = 1'b1;
                bus.cclu_cmd   = 2'b11;
                state_nxt      = FWAIT;
            end
            FWAIT: begin
                bus.flush_done = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= IDW'(NUM_REQ - 1);
            grant        <= '0;
            cmd_q        <= 2'b00;
            addr_q       <= '0;
            target_q     <= '0;
            counter_q    <= '0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            rsp_target_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.flush_req && pick_found) begin
                        grant        <= pick;
                        cmd_q        <= pick_cmd;
                        addr_q       <= lane_addr[pick];
                        target_q     <= lane_target[pick];
                        counter_q    <= lane_counter[pick];
                        ok_q         <= 1'b0;
                        err_q        <= (pick_cmd == 2'b11);
                        rsp_target_q <= '0;
                    end
                end
                WAIT: begin
                    ok_q  <= bus.cclu_valid;
                    err_q <= bus.cclu_error;
                end
                CAP:  rsp_target_q <= ok_q ? bus.cclu_target_out : '0;
                RESP: rr_ptr <= grant;
                default: ;
            endcase
        end
    end

`ifdef CCLU_ARB_STATS_EN
    logic [15:0] err_cnt;
    logic [15:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (reset || state == FWAIT) begin
            err_cnt <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
        end else if (state == RESP) begin
            if (err_q && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            if (grant_cnt[grant] != '1) grant_cnt[grant] <= grant_cnt[grant] + 16'd1;
        end
    end

    assign bus.err_count = err_cnt;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign bus.grant_count[g*16 +: 16] = grant_cnt[g];
    end
`endif
endmodule

// File: tb/tb_cclu_arbiter.sv
// Scoreboard bench for cclu_arbiter: stimulus queues expected responses, a negedge monitor checks them.
module tb_cclu_arbiter;
    localparam int NUM_REQ = 4;
    localparam int AW      = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cclu_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW)) bus ();

    cclu_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic          echo;
    logic [AW-1:0] tgt_drv;
    assign bus.cclu_target_out = echo ? bus.cclu_target : tgt_drv;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    id;
        logic          ok;
        logic          err;
        logic [AW-1:0] tgt;
        int unsigned   at;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push(input logic [1:0] id, input logic ok, input logic err,
                        input logic [AW-1:0] tgt, input int unsigned at);
        exp_t e;
        e.id = id; e.ok = ok; e.err = err; e.tgt = tgt; e.at = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_id %0d expected no response (cycle %0d)", bus.rsp_id, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_cycle",  64'(cyc),            64'(e.at));
                check("rsp_id",     64'(bus.rsp_id),     64'(e.id));
                check("rsp_ok",     64'(bus.rsp_ok),     64'(e.ok));
                check("rsp_error",  64'(bus.rsp_error),  64'(e.err));
                check("rsp_target", 64'(bus.rsp_target), 64'(e.tgt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int unsigned i, input logic [1:0] c, input logic [AW-1:0] a,
                            input logic [AW-1:0] t, input logic [AW-1:0] n);
        bus.req_cmd[i*2 +: 2]      = c;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_target[i*AW +: AW] = t;
        bus.req_counter[i*AW +: AW] = n;
    endtask

    int unsigned k;

    initial begin
        reset           = 1'b1;
        echo            = 1'b0;
        tgt_drv         = '0;
        bus.req_valid   = '0;
        bus.req_cmd     = '0;
        bus.req_addr    = '0;
        bus.req_target  = '0;
        bus.req_counter = '0;
        bus.flush_req   = 1'b0;
        bus.cclu_valid  = 1'b0;
        bus.cclu_error  = 1'b0;
        bus.cclu_full   = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        check("reset_busy",  64'(bus.busy),       64'd0);
        check("reset_cmd",   64'(bus.cclu_cmd),   64'd0);
        check("reset_clear", 64'(bus.cclu_clear), 64'd0);
        check("reset_done",  64'(bus.flush_done), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Single forwarded request
        set_lane(0, 2'b01, 32'h100, 32'h200, 32'd3);
        bus.cclu_valid = 1'b1;
        tgt_drv        = 32'h200;
        bus.req_valid  = 4'b0001;
        k = cyc;
        push(2'd0, 1'b1, 1'b0, 32'h200, k + 4);
        @(negedge clk);
        check("single_cmd_idle", 64'(bus.cclu_cmd), 64'd0);
        step();
        @(negedge clk);
        check("single_cmd_issue", 64'(bus.cclu_cmd),     64'd1);
        check("single_addr",      64'(bus.cclu_addr),    64'h100);
        check("single_counter",   64'(bus.cclu_counter), 64'd3);
        check("single_target",    64'(bus.cclu_target),  64'h200);
        step();
        @(negedge clk);
        check("single_cmd_wait",   64'(bus.cclu_cmd),    64'd0);
        check("single_target_hold", 64'(bus.cclu_target), 64'h200);
        while (cyc < k + 5) step();
        bus.req_valid = '0;
        step();

        // Round-robin with all requesters held
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int unsigned i = 0; i < NUM_REQ; i++)
            set_lane(i, 2'b01, 32'h40 * i, 32'h1000 + i, i);
        echo           = 1'b1;
        bus.cclu_valid = 1'b1;
        bus.cclu_error = 1'b0;
        bus.req_valid  = 4'b1111;
        k = cyc;
        for (int unsigned n = 0; n < 5; n++)
            push(2'(n % 4), 1'b1, 1'b0, 32'h1000 + (n % 4), k + 4 + 5 * n);
        while (cyc < k + 25) step();
        bus.req_valid = '0;
        echo          = 1'b0;
        step();

        // Local command 11
        set_lane(2, 2'b11, 32'h0, 32'h77, 32'h0);
        bus.req_valid = 4'b0100;
        k = cyc;
        push(2'd2, 1'b0, 1'b1, 32'h0, k + 1);
        step();
        @(negedge clk);
        check("local11_cmd", 64'(bus.cclu_cmd), 64'd0);
        step();
        bus.req_valid = '0;
        step();

        // Local command 00
        set_lane(2, 2'b00, 32'h0, 32'h77, 32'h0);
        bus.req_valid = 4'b0100;
        k = cyc;
        push(2'd2, 1'b0, 1'b0, 32'h0, k + 1);
        step();
        @(negedge clk);
        check("local00_cmd", 64'(bus.cclu_cmd), 64'd0);
        step();
        bus.req_valid = '0;
        step();

        // Flush takes priority over a simultaneous request
        set_lane(1, 2'b01, 32'h300, 32'h300, 32'd1);
        tgt_drv        = 32'h333;
        bus.cclu_valid = 1'b1;
        bus.flush_req  = 1'b1;
        bus.req_valid  = 4'b0010;
        k = cyc;
        push(2'd1, 1'b1, 1'b0, 32'h333, k + 7);
        step();
        bus.flush_req = 1'b0;
        @(negedge clk);
        check("flush_clear", 64'(bus.cclu_clear), 64'd1);
        check("flush_cmd",   64'(bus.cclu_cmd),   64'd3);
        check("flush_done_early", 64'(bus.flush_done), 64'd0);
        step();
        @(negedge clk);
        check("flush_done",      64'(bus.flush_done), 64'd1);
        check("flush_clear_off", 64'(bus.cclu_clear), 64'd0);
        check("flush_cmd_off",   64'(bus.cclu_cmd),   64'd0);
        step(); step();
        @(negedge clk);
        check("post_flush_issue", 64'(bus.cclu_cmd),  64'd1);
        check("post_flush_addr",  64'(bus.cclu_addr), 64'h300);
        while (cyc < k + 8) step();
        bus.req_valid = '0;
        step();

        // Push while full with CCLU error
        set_lane(2, 2'b01, 32'h500, 32'h600, 32'd9);
        bus.cclu_full  = 1'b1;
        bus.cclu_valid = 1'b0;
        bus.cclu_error = 1'b1;
        tgt_drv        = 32'hdead;
        bus.req_valid  = 4'b0100;
        k = cyc;
        push(2'd2, 1'b0, 1'b1, 32'h0, k + 4);
        step();
        @(negedge clk);
        check("full_cmd_fwd", 64'(bus.cclu_cmd),  64'd1);
        check("full_addr",    64'(bus.cclu_addr), 64'h500);
        while (cyc < k + 5) step();
        bus.req_valid  = '0;
        bus.cclu_full  = 1'b0;
        bus.cclu_error = 1'b0;
        bus.cclu_valid = 1'b1;
        step();

        // Reset while in WAIT drops the request and restores rr_ptr
        set_lane(0, 2'b01, 32'h700, 32'h800, 32'd2);
        bus.req_valid = 4'b0001;
        k = cyc;
        step(); step();
        @(negedge clk);
        check("wait_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("rst_wait_busy", 64'(bus.busy),     64'd0);
        check("rst_wait_cmd",  64'(bus.cclu_cmd), 64'd0);
        check("rst_wait_rsp",  64'(bus.rsp_valid), 64'd0);
        reset = 1'b0;
        bus.req_valid = '0;
        repeat (6) step();
        for (int unsigned i = 0; i < NUM_REQ; i++)
            set_lane(i, 2'b00, 32'h0, 32'h0, 32'h0);
        bus.req_valid = 4'b1111;
        k = cyc;
        push(2'd0, 1'b0, 1'b0, 32'h0, k + 1);
        step(); step();
        bus.req_valid = '0;
        step();
`ifdef CCLU_ARB_STATS_EN
        check("stat_err_count",   64'(bus.err_count),         64'd0);
        check("stat_grant_count", 64'(bus.grant_count[15:0]), 64'd1);
`endif

        repeat (5) step();
        check("pending_rsp", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
